// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite definitions: response codes, command-master FSM states and
// register addresses of the action's global interrupt/status slave.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Register map of the global interrupt/status slave.
    localparam logic [31:0] REG_ACTION_TYPE = 32'h0000_0010;
    localparam logic [31:0] REG_IRQ_W1C     = 32'h0000_0030;
    localparam logic [31:0] REG_IRQ_MASK    = 32'h0000_0034;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR   = 3'd1,
        ST_WR_B = 3'd2,
        ST_RD_A = 3'd3,
        ST_RD_D = 3'd4,
        ST_DONE = 3'd5
    } state_t;

endpackage : axi_lite_pkg

// File: rtl/axi_lite_cmd_master.sv
// Single-outstanding AXI4-Lite master driven by a valid/ready command and
// response interface. Optional per-transaction watchdog enabled by the macro
// AXI_LITE_CMD_MASTER_TIMEOUT_EN.
module axi_lite_cmd_master
    import axi_lite_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    // command
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
    // response
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic                    rsp_timeout,
    // AXI write address
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [2:0]              m_axi_awprot,
    // AXI write data
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    // AXI write response
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    input  logic [1:0]              m_axi_bresp,
    // AXI read address
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [2:0]              m_axi_arprot,
    // AXI read data
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    state_t                  state_q, state_d;
    logic                    cmd_ready_q, cmd_ready_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q, wvalid_d;
    logic                    bready_q, bready_d;
    logic                    arvalid_q, arvalid_d;
    logic                    rready_q, rready_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]              rsp_resp_q, rsp_resp_d;

`ifdef AXI_LITE_CMD_MASTER_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             rsp_timeout_q, rsp_timeout_d;
    logic             busy;
    logic             hs;

    // Watchdog qualifiers: in an AXI phase, and whether that phase made progress.
    assign busy = (state_q == ST_WR) || (state_q == ST_WR_B) ||
                  (state_q == ST_RD_A) || (state_q == ST_RD_D);
    assign hs   = ((state_q == ST_WR) && ((awvalid_q && m_axi_awready) ||
                                          (wvalid_q && m_axi_wready))) ||
                  ((state_q == ST_WR_B) && m_axi_bvalid) ||
                  ((state_q == ST_RD_A) && m_axi_arready) ||
                  ((state_q == ST_RD_D) && m_axi_rvalid);

    assign rsp_timeout = rsp_timeout_q;
`else
    logic unused_tmo;

    // Watchdog is not built; its limit is deliberately unused.
    assign unused_tmo  = ^TIMEOUT_CYCLES;
    assign rsp_timeout = 1'b0;
`endif

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b1;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= RESP_OKAY;
`ifdef AXI_LITE_CMD_MASTER_TIMEOUT_EN
            tmo_cnt_q     <= '0;
            rsp_timeout_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
`ifdef AXI_LITE_CMD_MASTER_TIMEOUT_EN
            tmo_cnt_q     <= tmo_cnt_d;
            rsp_timeout_q <= rsp_timeout_d;
`endif
        end
    end

    // Next-state and next-output logic for the transaction FSM.
    always_comb begin
        state_d     = state_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
`ifdef AXI_LITE_CMD_MASTER_TIMEOUT_EN
        tmo_cnt_d     = tmo_cnt_q;
        rsp_timeout_d = rsp_timeout_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    wstrb_d = cmd_wstrb;
`ifdef AXI_LITE_CMD_MASTER_TIMEOUT_EN
                    rsp_timeout_d = 1'b0;
`endif
                    if (cmd_write) begin
                        state_d   = ST_WR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = ST_RD_A;
                        arvalid_d = 1'b1;
                    end
                end
            end
            ST_WR: begin
                // Address and data channels complete independently.
                if (awvalid_q && m_axi_awready) begin
                    awvalid_d = 1'b0;
                end
                if (wvalid_q && m_axi_wready) begin
                    wvalid_d = 1'b0;
                end
                if (!awvalid_d && !wvalid_d) begin
                    state_d  = ST_WR_B;
                    bready_d = 1'b1;
                end
            end
            ST_WR_B: begin
                if (m_axi_bvalid) begin
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_resp_d  = m_axi_bresp;
                    rsp_rdata_d = '0;
                    state_d     = ST_DONE;
                end
            end
            ST_RD_A: begin
                if (m_axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_RD_D;
                end
            end
            ST_RD_D: begin
                if (m_axi_rvalid) begin
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_resp_d  = m_axi_rresp;
                    rsp_rdata_d = m_axi_rdata;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef AXI_LITE_CMD_MASTER_TIMEOUT_EN
        // Abandon a stalled phase; progress in the expiry cycle takes priority.
        if (busy && !hs && (tmo_cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1))) begin
            awvalid_d     = 1'b0;
            wvalid_d      = 1'b0;
            bready_d      = 1'b0;
            arvalid_d     = 1'b0;
            rready_d      = 1'b0;
            rsp_valid_d   = 1'b1;
            rsp_resp_d    = RESP_SLVERR;
            rsp_rdata_d   = '0;
            rsp_timeout_d = 1'b1;
            state_d       = ST_DONE;
        end
        if (state_d != state_q) begin
            tmo_cnt_d = '0;
        end else if (busy && (tmo_cnt_q < CNT_W'(TIMEOUT_CYCLES))) begin
            tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
        end
`endif

        cmd_ready_d = (state_d == ST_IDLE);
    end

    assign cmd_ready     = cmd_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_resp      = rsp_resp_q;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_bready  = bready_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_rready  = rready_q;

endmodule : axi_lite_cmd_master
